// File: rtl/dyn_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus saturating-counter table,
// looked up combinationally in IF and updated from the ID-stage resolution.
module dyn_branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int TAG_W    = 8,
    parameter int CTR_BITS = 2,
    parameter int GSHARE   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC_curr,
    output logic        predict_taken,
    output logic        btb_hit,
    output logic [15:0] PC_pred,
    input  logic        stall,
    input  logic        flush,
    input  logic        is_branch,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic [15:0] IF_ID_PC_curr,
    output logic        mispredict,
    output logic [15:0] recover_pc
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [15:0]         r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [IDX_W-1:0]    r_ghr;

    logic                r_id_valid;
    logic                r_id_pt;
    logic [15:0]         r_id_target;
    logic [IDX_W-1:0]    r_id_cidx;

    // IF-side lookup
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_cidx;
    logic                w_hit;
    logic                w_pt;

    assign w_idx  = PC_curr[IDX_W:1];
    assign w_tag  = PC_curr[IDX_W+TAG_W:IDX_W+1];
    assign w_cidx = (GSHARE != 0) ? (w_idx ^ r_ghr) : w_idx;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pt   = w_hit && r_ctr[w_cidx][CTR_BITS-1];

    assign btb_hit       = w_hit;
    assign predict_taken = w_pt;
    assign PC_pred       = w_pt ? r_target[w_idx] : (PC_curr + 16'd2);

    // ID-side resolution
    logic [IDX_W-1:0]    w_u_idx;
    logic [TAG_W-1:0]    w_u_tag;
    logic                w_u_hit;
    logic                w_res;
    logic                w_mis;
    logic [CTR_BITS-1:0] w_ctr_cur;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic [IDX_W:0]      w_ghr_shift;

    assign w_u_idx = IF_ID_PC_curr[IDX_W:1];
    assign w_u_tag = IF_ID_PC_curr[IDX_W+TAG_W:IDX_W+1];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_res   = is_branch && r_id_valid && !stall;
    assign w_mis   = w_res && ((actual_taken && (!r_id_pt || (r_id_target != actual_target)))
                              || (!actual_taken && r_id_pt));

    assign mispredict = w_mis;
    assign recover_pc = !w_mis       ? 16'h0000 :
                        actual_taken ? actual_target : (IF_ID_PC_curr + 16'd2);

    assign w_ctr_cur   = r_ctr[r_id_cidx];
    assign w_ghr_shift = {r_ghr, actual_taken};

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (actual_taken && !w_u_hit) begin
            w_ctr_next = CTR_WT;
        end else if (actual_taken) begin
            if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + 1'b1;
        end else begin
            if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - 1'b1;
        end
    end

    // Prediction travelling with the instruction into ID; flush beats stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid  <= 1'b0;
            r_id_pt     <= 1'b0;
            r_id_target <= 16'h0000;
            r_id_cidx   <= '0;
        end else if (flush) begin
            r_id_valid  <= 1'b0;
        end else if (!stall) begin
            r_id_valid  <= 1'b1;
            r_id_pt     <= w_pt;
            r_id_target <= PC_pred;
            r_id_cidx   <= w_cidx;
        end
    end

    // Taken resolutions write valid/tag/target; on a hit the tag is unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 16'h0000;
                r_ctr[i]    <= CTR_WNT;
            end
            r_ghr <= '0;
        end else if (w_res) begin
            r_ctr[r_id_cidx] <= w_ctr_next;
            if (actual_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= actual_target;
            end
            if (GSHARE != 0) r_ghr <= w_ghr_shift[IDX_W-1:0];
        end
    end
endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Directed bench for dyn_branch_predictor: bimodal instance for the main
// scenarios, a gshare instance for the alternating-pattern scenario.
module tb_dyn_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] PC_curr;
    logic        stall, flush, is_branch, actual_taken;
    logic [15:0] actual_target, IF_ID_PC_curr;

    logic        b_pt, b_hit, b_mis;
    logic [15:0] b_pred, b_rec;
    logic        g_pt, g_hit, g_mis;
    logic [15:0] g_pred, g_rec;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic        s_pt, s_hit, s_mis;
    logic [15:0] s_pred, s_rec;

    always #5 clk = ~clk;

    dyn_branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .PC_curr(PC_curr),
        .predict_taken(b_pt), .btb_hit(b_hit), .PC_pred(b_pred),
        .stall(stall), .flush(flush), .is_branch(is_branch),
        .actual_taken(actual_taken), .actual_target(actual_target),
        .IF_ID_PC_curr(IF_ID_PC_curr), .mispredict(b_mis), .recover_pc(b_rec)
    );

    dyn_branch_predictor #(.GSHARE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .PC_curr(PC_curr),
        .predict_taken(g_pt), .btb_hit(g_hit), .PC_pred(g_pred),
        .stall(stall), .flush(flush), .is_branch(is_branch),
        .actual_taken(actual_taken), .actual_target(actual_target),
        .IF_ID_PC_curr(IF_ID_PC_curr), .mispredict(g_mis), .recover_pc(g_rec)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lookup in one cycle, resolve in ID the next cycle
    task automatic do_branch(input logic [15:0] pc, input logic tk,
                             input logic [15:0] tgt, input bit g);
        @(posedge clk); #1;
        PC_curr = pc; is_branch = 1'b0;
        @(negedge clk);
        s_pt   = g ? g_pt   : b_pt;
        s_hit  = g ? g_hit  : b_hit;
        s_pred = g ? g_pred : b_pred;
        @(posedge clk); #1;
        PC_curr = 16'h1000; is_branch = 1'b1; IF_ID_PC_curr = pc;
        actual_taken = tk; actual_target = tgt;
        @(negedge clk);
        s_mis = g ? g_mis : b_mis;
        s_rec = g ? g_rec : b_rec;
        @(posedge clk); #1;
        is_branch = 1'b0;
        $display("br pc=%h tk=%b hit=%b pt=%b pred=%h mis=%b rec=%h",
                 pc, tk, s_hit, s_pt, s_pred, s_mis, s_rec);
    endtask

    task automatic look(input logic [15:0] pc);
        @(posedge clk); #1;
        PC_curr = pc; is_branch = 1'b0;
        @(negedge clk);
        s_pt = b_pt; s_hit = b_hit; s_pred = b_pred;
        $display("lookup pc=%h hit=%b pt=%b pred=%h", pc, s_hit, s_pt, s_pred);
    endtask

    initial begin
        rst_n = 1'b0; PC_curr = 16'h0010; stall = 1'b0; flush = 1'b0;
        is_branch = 1'b1; actual_taken = 1'b1; actual_target = 16'h0040;
        IF_ID_PC_curr = 16'h0010;
        #12;
        chk("rst_pt",   {15'd0, b_pt},  16'h0000);
        chk("rst_hit",  {15'd0, b_hit}, 16'h0000);
        chk("rst_pred", b_pred,         16'h0012);
        chk("rst_mis",  {15'd0, b_mis}, 16'h0000);
        chk("rst_rec",  b_rec,          16'h0000);
        is_branch = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Cold not-taken: no mispredict, BTB stays empty
        do_branch(16'h0010, 1'b0, 16'h0040, 0);
        chk("cold_nt_pt",   {15'd0, s_pt},  16'h0000);
        chk("cold_nt_pred", s_pred,         16'h0012);
        chk("cold_nt_mis",  {15'd0, s_mis}, 16'h0000);
        look(16'h0010);
        chk("empty_hit",    {15'd0, s_hit}, 16'h0000);

        // Cold taken: allocate
        do_branch(16'h0010, 1'b1, 16'h0040, 0);
        chk("cold_t_mis",   {15'd0, s_mis}, 16'h0001);
        chk("cold_t_rec",   s_rec,          16'h0040);
        look(16'h0010);
        chk("alloc_hit",    {15'd0, s_hit}, 16'h0001);
        chk("alloc_pt",     {15'd0, s_pt},  16'h0001);
        chk("alloc_pred",   s_pred,         16'h0040);

        // Taken x3 saturates at 3 with no mispredicts
        for (int k = 0; k < 3; k++) begin
            do_branch(16'h0010, 1'b1, 16'h0040, 0);
            chk("sat_t_pt",  {15'd0, s_pt},  16'h0001);
            chk("sat_t_mis", {15'd0, s_mis}, 16'h0000);
        end
        // 3 -> 2 -> 1: both still predicted taken
        do_branch(16'h0010, 1'b0, 16'h0000, 0);
        chk("nt1_mis", {15'd0, s_mis}, 16'h0001);
        chk("nt1_rec", s_rec,          16'h0012);
        do_branch(16'h0010, 1'b0, 16'h0000, 0);
        chk("nt2_mis", {15'd0, s_mis}, 16'h0001);
        // 1 -> 0 -> stays 0
        do_branch(16'h0010, 1'b0, 16'h0000, 0);
        chk("nt3_pt",   {15'd0, s_pt},  16'h0000);
        chk("nt3_hit",  {15'd0, s_hit}, 16'h0001);
        chk("nt3_pred", s_pred,         16'h0012);
        chk("nt3_mis",  {15'd0, s_mis}, 16'h0000);
        do_branch(16'h0010, 1'b0, 16'h0000, 0);
        chk("nt4_mis",  {15'd0, s_mis}, 16'h0000);
        // 0 -> 1 -> 2: floor held, so two taken needed to predict taken
        do_branch(16'h0010, 1'b1, 16'h0040, 0);
        chk("floor_pt",  {15'd0, s_pt},  16'h0000);
        chk("floor_mis", {15'd0, s_mis}, 16'h0001);
        chk("floor_rec", s_rec,          16'h0040);
        do_branch(16'h0010, 1'b1, 16'h0040, 0);
        chk("c1_pt",     {15'd0, s_pt},  16'h0000);

        // Alias at same index, different tag
        look(16'h0210);
        chk("alias_hit",  {15'd0, s_hit}, 16'h0000);
        chk("alias_pred", s_pred,         16'h0212);

        // Wrong target on a hit (counter 2 -> 3)
        do_branch(16'h0010, 1'b1, 16'h0050, 0);
        chk("wt_pred", s_pred,         16'h0040);
        chk("wt_mis",  {15'd0, s_mis}, 16'h0001);
        chk("wt_rec",  s_rec,          16'h0050);
        look(16'h0010);
        chk("wt_new_pred", s_pred, 16'h0050);

        // Stall for 3 cycles, single update when it drops (counter 3 -> 2)
        @(posedge clk); #1;
        PC_curr = 16'h0010; is_branch = 1'b0;
        @(posedge clk); #1;
        PC_curr = 16'h1000; stall = 1'b1; is_branch = 1'b1;
        IF_ID_PC_curr = 16'h0010; actual_taken = 1'b0; actual_target = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_mis", {15'd0, b_mis}, 16'h0000);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_mis", {15'd0, b_mis}, 16'h0001);
        chk("unstall_rec", b_rec,          16'h0012);
        @(posedge clk); #1;
        is_branch = 1'b0;
        do_branch(16'h0010, 1'b0, 16'h0000, 0);
        chk("post_stall_pt", {15'd0, s_pt}, 16'h0001);
        look(16'h0010);
        chk("post_stall_c1", {15'd0, s_pt}, 16'h0000);

        // Flush then is_branch next cycle: ignored
        @(posedge clk); #1;
        PC_curr = 16'h0010; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; PC_curr = 16'h1000; is_branch = 1'b1;
        IF_ID_PC_curr = 16'h0010; actual_taken = 1'b1; actual_target = 16'h0050;
        @(negedge clk);
        chk("flush_mis", {15'd0, b_mis}, 16'h0000);
        @(posedge clk); #1;
        is_branch = 1'b0;
        look(16'h0010);
        chk("flush_noupd", {15'd0, s_pt}, 16'h0000);

        // Flush and stall together: flush wins
        @(posedge clk); #1;
        PC_curr = 16'h0010;
        @(posedge clk); #1;
        PC_curr = 16'h1000; flush = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; stall = 1'b0; is_branch = 1'b1;
        IF_ID_PC_curr = 16'h0010; actual_taken = 1'b1; actual_target = 16'h0050;
        @(negedge clk);
        chk("fs_mis", {15'd0, b_mis}, 16'h0000);
        @(posedge clk); #1;
        is_branch = 1'b0;
        look(16'h0010);
        chk("fs_noupd", {15'd0, s_pt}, 16'h0000);

        // Address wrap at 0xFFFE
        do_branch(16'hFFFE, 1'b1, 16'h0100, 0);
        chk("wrap_pred", s_pred,         16'h0000);
        chk("wrap_mis",  {15'd0, s_mis}, 16'h0001);
        chk("wrap_rec",  s_rec,          16'h0100);
        do_branch(16'hFFFE, 1'b0, 16'h0000, 0);
        chk("wrap2_pt",  {15'd0, s_pt},  16'h0001);
        chk("wrap2_rec", s_rec,          16'h0000);

        // Gshare: alternating T/N after reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            do_branch(16'h0010, (k % 2) == 0, 16'h0040, 1);
        end
        for (int k = 0; k < 8; k++) begin
            do_branch(16'h0010, (k % 2) == 0, 16'h0040, 1);
            chk("gs_pt",  {15'd0, s_pt},  (k % 2) == 0 ? 16'h0001 : 16'h0000);
            chk("gs_mis", {15'd0, s_mis}, 16'h0000);
        end

        // Asynchronous reset mid-operation
        @(posedge clk); #1;
        PC_curr = 16'h0010;
        @(negedge clk);
        chk("pre_rst_hit", {15'd0, g_hit}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_hit",  {15'd0, g_hit}, 16'h0000);
        chk("async_rst_pt",   {15'd0, g_pt},  16'h0000);
        chk("async_rst_pred", g_pred,         16'h0012);
        @(negedge clk); rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
